axis_merge_rr_2x1: RTL and testbench
====================================

# axis_merge_rr_2x1

Two-input, one-output AXI-Stream packet merger with round-robin arbitration. Sits directly downstream of the 1x2 AXI-Stream switch and recombines its m0/m1 branches, or any two independent producers, into one stream. A grant is held for a whole packet (released only on an accepted `tlast` beat), so packets never interleave. The output is registered through a full-throughput skid slice.

## Interface
- `DATAW`, 48: tdata width in bits. Must be a multiple of 8.
- `TID_FROM_PORT`, 1: when 1, `m_axis_tid` carries the granted port index. When 0, it carries the source `tid`.
- `aclk` in 1: single clock. All logic is rising-edge.
- `areset` in 1: reset, synchronous to `aclk`, active-high.
- `s0_axis_tdata` in DATAW: input 0 data.
- `s0_axis_tvalid` in 1 / `s0_axis_tready` out 1: input 0 handshake.
- `s0_axis_tuser`, `s0_axis_tlast`, `s0_axis_tid`, `s0_axis_tdest` in 1 each: input 0 sideband.
- `s0_axis_tstrb`, `s0_axis_tkeep` in DATAW/8: input 0 byte qualifiers.
- `s1_axis_*`: identical set for input 1.
- `m_axis_tdata` out DATAW, `m_axis_tvalid` out 1, `m_axis_tready` in 1: merged output.
- `m_axis_tuser`, `m_axis_tlast`, `m_axis_tid`, `m_axis_tdest` out 1 each; `m_axis_tstrb`, `m_axis_tkeep` out DATAW/8.
- `grant` out 2: one-hot current owner. `2'b00` when idle.
- `pkt_cnt0`, `pkt_cnt1` out 16: completed packets per input, saturating at 16'hFFFF.

## Operation
- Arbiter FSM states: IDLE, LOCK0, LOCK1.
- IDLE:
  - If exactly one `sN_tvalid` is high, go to LOCKN.
  - If both are high, grant the port that is not `last_grant`. `last_grant` resets to 1, so port 0 wins the first tie.
  - If neither is high, stay in IDLE.
- LOCKN:
  - `sN_tready` = slice input ready. The other port's tready = 0.
  - The beat is forwarded into the slice on `sN_tvalid && sN_tready`.
  - On an accepted beat with `tlast`=1: `last_grant` <= N, `pkt_cntN` increments (saturating), next state is IDLE.
- In IDLE, both `sN_tready` = 0. No beat is accepted during the arbitration cycle.
- All sideband fields pass through unchanged, except `tid` when `TID_FROM_PORT`=1 (then tid = N).
- Skid slice: 2-entry register stage.
  - Input ready = not full.
  - No combinational path from `m_axis_tready` to `sN_tready`.
  - Sustains 1 beat/cycle under continuous `m_axis_tready`.
- The output obeys AXIS rules: once `m_axis_tvalid` is asserted, data and sideband stay stable until `m_axis_tready`.
- A source that drops `tvalid` mid-packet keeps the lock. The arbiter never times out.

## Timing
- Reset values:
  - FSM = IDLE, `last_grant` = 1.
  - `grant` = 0, both `sN_tready` = 0.
  - `m_axis_tvalid` = 0; all `m_axis_*` data/sideband = 0.
  - Slice empty, `pkt_cnt0` = `pkt_cnt1` = 0.
- Arbitration costs 1 cycle. The first beat can be accepted the cycle after tvalid is seen in IDLE.
- Latency from accepted input beat to `m_axis_tvalid` is 1 cycle (slice empty, tready high).
- Packet of L beats with no backpressure:
  - Occupies L+1 input cycles.
  - Back-to-back packets from alternating ports give a throughput of L/(L+1).
- A tlast accept and a new request in the same cycle: the FSM returns to IDLE first. The new grant starts one cycle later.
- Slice full: `sN_tready` falls in the same cycle the state register shows full. No beat is lost or duplicated.
- `areset` mid-packet:
  - Slice contents are discarded and the FSM returns to IDLE next cycle.
  - The truncated packet is not completed. Upstream is responsible for re-framing.
- Counters update the cycle after the tlast handshake.

## Structure
- Shared `axis_pkg` holds:
  - `arb_state_t` enum (IDLE, LOCK0, LOCK1).
  - The packed struct `axis_beat_t` {tdata, tstrb, tkeep, tuser, tlast, tid, tdest}, parameterised by DATAW through a package localparam or typedef in the module.
- Sub-module `axis_skid_slice`: generic 2-entry AXIS register slice on `axis_beat_t`. It is reused by other stages.

## Test plan
- **Single source:** s0 sends 4-beat packet tdata 1..4, `m_axis_tready`=1.
  - m_axis shows 1..4 on consecutive cycles, first beat 2 cycles after s0_tvalid rises.
  - tlast on beat 4; `pkt_cnt0`=1; tid=0.
- **Tie after reset:** both inputs valid simultaneously, 2-beat packets A (s0) and B (s1).
  - Output is A0 A1 B0 B1 with no interleave.
  - Repeat tie: s0 first again, since `last_grant` is now 1.
- **Fairness:** s0 continuously valid, s1 valid.
  - Packets alternate s0, s1, s0, s1.
  - `pkt_cnt0`/`pkt_cnt1` differ by at most 1 after 20 packets.
- **Backpressure:** random `m_axis_tready` (50%) on a 16-beat packet.
  - Every beat is seen exactly once, in order.
  - Output stays stable while valid && !ready.
  - `s0_tready` never depends combinationally on `m_axis_tready`.
- **Reset mid-packet:** `areset` on beat 3 of 8.
  - Next cycle: `m_axis_tvalid`=0, `grant`=0, counters 0.
  - A following 2-beat packet from s1 passes intact.
- **Saturation:** force 65 537 single-beat packets on s1.
  - `pkt_cnt1` holds at 16'hFFFF.
  - `tid`=1 with `TID_FROM_PORT`=1; source tid passed through with 0.

Source files
------------

// File: rtl/axis_pkg.sv
`default_nettype none
// ============================================================================
// axis_pkg : shared arbiter state encoding and default AXI-Stream beat layout
// Rev 1.0
// ============================================================================
package axis_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } arb_state_t;

    localparam int AXIS_DATAW = 48;

    typedef struct packed {
        logic [AXIS_DATAW-1:0]   tdata;
        logic [AXIS_DATAW/8-1:0] tstrb;
        logic [AXIS_DATAW/8-1:0] tkeep;
        logic                    tuser;
        logic                    tlast;
        logic                    tid;
        logic                    tdest;
    } axis_beat_t;

endpackage
`default_nettype wire

// File: rtl/axis_skid_slice.sv
`default_nettype none
// ============================================================================
// axis_skid_slice : 2-entry AXI-Stream register slice, registered ready path
// Rev 1.0
// ============================================================================
module axis_skid_slice
    import axis_pkg::*;
#(
    parameter type beat_t = axis_beat_t
) (
    input  logic  clk,
    input  logic  rst,
    input  beat_t in_beat,
    input  logic  in_valid,
    output logic  in_ready,
    output beat_t out_beat,
    output logic  out_valid,
    input  logic  out_ready
);

    beat_t main_beat;
    beat_t skid_beat;
    logic  main_valid;
    logic  skid_valid;

    // Ready depends only on the skid register, never on out_ready.
    assign in_ready  = !skid_valid;
    assign out_beat  = main_beat;
    assign out_valid = main_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            main_beat  <= '0;
            skid_beat  <= '0;
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else if (out_ready || !main_valid) begin
            if (skid_valid) begin
                main_beat  <= skid_beat;
                main_valid <= 1'b1;
                skid_valid <= 1'b0;
            end else begin
                main_valid <= in_valid;
                if (in_valid) begin
                    main_beat <= in_beat;
                end
            end
        end else if (in_valid && !skid_valid) begin
            skid_beat  <= in_beat;
            skid_valid <= 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/axis_merge_rr_2x1.sv
`default_nettype none
// ============================================================================
// axis_merge_rr_2x1 : 2:1 AXI-Stream packet merger, round-robin, packet lock
// Rev 1.0
// ============================================================================
module axis_merge_rr_2x1
    import axis_pkg::*;
#(
    parameter int DATAW         = 48,
    parameter bit TID_FROM_PORT = 1'b1
) (
    input  logic               aclk,
    input  logic               areset,
    input  logic [DATAW-1:0]   s0_axis_tdata,
    input  logic               s0_axis_tvalid,
    output logic               s0_axis_tready,
    input  logic               s0_axis_tuser,
    input  logic               s0_axis_tlast,
    input  logic               s0_axis_tid,
    input  logic               s0_axis_tdest,
    input  logic [DATAW/8-1:0] s0_axis_tstrb,
    input  logic [DATAW/8-1:0] s0_axis_tkeep,
    input  logic [DATAW-1:0]   s1_axis_tdata,
    input  logic               s1_axis_tvalid,
    output logic               s1_axis_tready,
    input  logic               s1_axis_tuser,
    input  logic               s1_axis_tlast,
    input  logic               s1_axis_tid,
    input  logic               s1_axis_tdest,
    input  logic [DATAW/8-1:0] s1_axis_tstrb,
    input  logic [DATAW/8-1:0] s1_axis_tkeep,
    output logic [DATAW-1:0]   m_axis_tdata,
    output logic               m_axis_tvalid,
    input  logic               m_axis_tready,
    output logic               m_axis_tuser,
    output logic               m_axis_tlast,
    output logic               m_axis_tid,
    output logic               m_axis_tdest,
    output logic [DATAW/8-1:0] m_axis_tstrb,
    output logic [DATAW/8-1:0] m_axis_tkeep,
    output logic [1:0]         grant,
    output logic [15:0]        pkt_cnt0,
    output logic [15:0]        pkt_cnt1
);

    typedef struct packed {
        logic [DATAW-1:0]   tdata;
        logic [DATAW/8-1:0] tstrb;
        logic [DATAW/8-1:0] tkeep;
        logic               tuser;
        logic               tlast;
        logic               tid;
        logic               tdest;
    } beat_t;

    arb_state_t  state;
    arb_state_t  state_next;
    logic        last_grant;
    logic [15:0] cnt0;
    logic [15:0] cnt1;
    logic        sel1;
    logic        src_tid;
    logic        in_valid;
    logic        slice_ready;
    logic        accept;
    beat_t       in_beat;
    beat_t       out_beat;

    assign sel1     = (state == LOCK1);
    assign in_valid = ((state == LOCK0) && s0_axis_tvalid) ||
                      ((state == LOCK1) && s1_axis_tvalid);
    assign accept   = in_valid && slice_ready;

    always_comb begin
        state_next     = state;
        s0_axis_tready = 1'b0;
        s1_axis_tready = 1'b0;
        case (state)
            IDLE: begin
                if (s0_axis_tvalid && s1_axis_tvalid) begin
                    state_next = last_grant ? LOCK0 : LOCK1;
                end else if (s0_axis_tvalid) begin
                    state_next = LOCK0;
                end else if (s1_axis_tvalid) begin
                    state_next = LOCK1;
                end
            end
            LOCK0: begin
                s0_axis_tready = slice_ready;
                if (s0_axis_tvalid && slice_ready && s0_axis_tlast) begin
                    state_next = IDLE;
                end
            end
            LOCK1: begin
                s1_axis_tready = slice_ready;
                if (s1_axis_tvalid && slice_ready && s1_axis_tlast) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        in_beat = '0;
        src_tid = 1'b0;
        if (sel1) begin
            in_beat.tdata = s1_axis_tdata;
            in_beat.tstrb = s1_axis_tstrb;
            in_beat.tkeep = s1_axis_tkeep;
            in_beat.tuser = s1_axis_tuser;
            in_beat.tlast = s1_axis_tlast;
            in_beat.tdest = s1_axis_tdest;
            src_tid       = s1_axis_tid;
        end else begin
            in_beat.tdata = s0_axis_tdata;
            in_beat.tstrb = s0_axis_tstrb;
            in_beat.tkeep = s0_axis_tkeep;
            in_beat.tuser = s0_axis_tuser;
            in_beat.tlast = s0_axis_tlast;
            in_beat.tdest = s0_axis_tdest;
            src_tid       = s0_axis_tid;
        end
        in_beat.tid = TID_FROM_PORT ? sel1 : src_tid;
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            cnt0       <= 16'd0;
            cnt1       <= 16'd0;
        end else begin
            state <= state_next;
            if (accept && in_beat.tlast) begin
                last_grant <= sel1;
                if (!sel1 && (cnt0 != 16'hFFFF)) begin
                    cnt0 <= cnt0 + 16'd1;
                end
                if (sel1 && (cnt1 != 16'hFFFF)) begin
                    cnt1 <= cnt1 + 16'd1;
                end
            end
        end
    end

    axis_skid_slice #(
        .beat_t (beat_t)
    ) u_slice (
        .clk       (aclk),
        .rst       (areset),
        .in_beat   (in_beat),
        .in_valid  (in_valid),
        .in_ready  (slice_ready),
        .out_beat  (out_beat),
        .out_valid (m_axis_tvalid),
        .out_ready (m_axis_tready)
    );

    assign m_axis_tdata = out_beat.tdata;
    assign m_axis_tstrb = out_beat.tstrb;
    assign m_axis_tkeep = out_beat.tkeep;
    assign m_axis_tuser = out_beat.tuser;
    assign m_axis_tlast = out_beat.tlast;
    assign m_axis_tid   = out_beat.tid;
    assign m_axis_tdest = out_beat.tdest;

    assign grant    = {(state == LOCK1), (state == LOCK0)};
    assign pkt_cnt0 = cnt0;
    assign pkt_cnt1 = cnt1;

endmodule
`default_nettype wire

// File: tb/tb_axis_merge_rr_2x1.sv
`default_nettype none
// ============================================================================
// tb_axis_merge_rr_2x1 : directed self-checking bench for the 2:1 merger
// Rev 1.0
// ============================================================================
module tb_axis_merge_rr_2x1;

    localparam int DATAW = 48;
    localparam int KW    = DATAW / 8;

    logic             aclk = 1'b0;
    logic             areset = 1'b1;
    logic [DATAW-1:0] s0_tdata = '0, s1_tdata = '0;
    logic             s0_tvalid = 1'b0, s1_tvalid = 1'b0;
    logic             s0_tuser = 1'b0, s1_tuser = 1'b0;
    logic             s0_tlast = 1'b0, s1_tlast = 1'b0;
    logic             s0_tid = 1'b0, s1_tid = 1'b0;
    logic             s0_tdest = 1'b0, s1_tdest = 1'b0;
    logic [KW-1:0]    s0_tstrb = '0, s1_tstrb = '0;
    logic [KW-1:0]    s0_tkeep = '0, s1_tkeep = '0;
    logic             m_tready = 1'b1;
    logic             s0_tready, s1_tready;
    logic [DATAW-1:0] m_tdata;
    logic             m_tvalid, m_tuser, m_tlast, m_tid, m_tdest;
    logic [KW-1:0]    m_tstrb, m_tkeep;
    logic [1:0]       grant;
    logic [15:0]      pkt_cnt0, pkt_cnt1;

    logic             src_s0_tready, src_s1_tready;
    logic [DATAW-1:0] src_tdata;
    logic             src_tvalid, src_tuser, src_tlast, src_tid, src_tdest;
    logic [KW-1:0]    src_tstrb, src_tkeep;
    logic [1:0]       src_grant;
    logic [15:0]      src_cnt0, src_cnt1;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    logic rand_ready = 1'b0;
    logic rdy_before;
    logic prev_stall = 1'b0;
    logic [63:0] prev_snap = '0;

    typedef struct {
        logic [DATAW-1:0] d;
        logic             last;
        logic             user;
        logic             tid;
        logic             tid_src;
        logic             dest;
        logic [KW-1:0]    keep;
        int               cyc;
    } rec_t;
    rec_t q[$];

    always #5 aclk = ~aclk;
    always @(posedge aclk) cyc <= cyc + 1;

    axis_merge_rr_2x1 #(.DATAW(DATAW), .TID_FROM_PORT(1'b1)) dut (
        .aclk(aclk), .areset(areset),
        .s0_axis_tdata(s0_tdata), .s0_axis_tvalid(s0_tvalid), .s0_axis_tready(s0_tready),
        .s0_axis_tuser(s0_tuser), .s0_axis_tlast(s0_tlast), .s0_axis_tid(s0_tid),
        .s0_axis_tdest(s0_tdest), .s0_axis_tstrb(s0_tstrb), .s0_axis_tkeep(s0_tkeep),
        .s1_axis_tdata(s1_tdata), .s1_axis_tvalid(s1_tvalid), .s1_axis_tready(s1_tready),
        .s1_axis_tuser(s1_tuser), .s1_axis_tlast(s1_tlast), .s1_axis_tid(s1_tid),
        .s1_axis_tdest(s1_tdest), .s1_axis_tstrb(s1_tstrb), .s1_axis_tkeep(s1_tkeep),
        .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
        .m_axis_tuser(m_tuser), .m_axis_tlast(m_tlast), .m_axis_tid(m_tid),
        .m_axis_tdest(m_tdest), .m_axis_tstrb(m_tstrb), .m_axis_tkeep(m_tkeep),
        .grant(grant), .pkt_cnt0(pkt_cnt0), .pkt_cnt1(pkt_cnt1)
    );

    // Same stimulus, source tid passed through instead of the port index.
    axis_merge_rr_2x1 #(.DATAW(DATAW), .TID_FROM_PORT(1'b0)) dut_src (
        .aclk(aclk), .areset(areset),
        .s0_axis_tdata(s0_tdata), .s0_axis_tvalid(s0_tvalid), .s0_axis_tready(src_s0_tready),
        .s0_axis_tuser(s0_tuser), .s0_axis_tlast(s0_tlast), .s0_axis_tid(s0_tid),
        .s0_axis_tdest(s0_tdest), .s0_axis_tstrb(s0_tstrb), .s0_axis_tkeep(s0_tkeep),
        .s1_axis_tdata(s1_tdata), .s1_axis_tvalid(s1_tvalid), .s1_axis_tready(src_s1_tready),
        .s1_axis_tuser(s1_tuser), .s1_axis_tlast(s1_tlast), .s1_axis_tid(s1_tid),
        .s1_axis_tdest(s1_tdest), .s1_axis_tstrb(s1_tstrb), .s1_axis_tkeep(s1_tkeep),
        .m_axis_tdata(src_tdata), .m_axis_tvalid(src_tvalid), .m_axis_tready(m_tready),
        .m_axis_tuser(src_tuser), .m_axis_tlast(src_tlast), .m_axis_tid(src_tid),
        .m_axis_tdest(src_tdest), .m_axis_tstrb(src_tstrb), .m_axis_tkeep(src_tkeep),
        .grant(src_grant), .pkt_cnt0(src_cnt0), .pkt_cnt1(src_cnt1)
    );

    task automatic check(input string name, input logic [79:0] obs, input logic [79:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    function automatic rec_t at(input int i);
        rec_t r;
        r = '{default: 0};
        if (i < q.size()) r = q[i];
        return r;
    endfunction

    // Output monitor: records every handshake and checks hold-while-stalled.
    always @(negedge aclk) begin
        #1;
        if (prev_stall) begin
            check("stall_valid", m_tvalid, 1'b1);
            check("stall_stable", {m_tdata, m_tkeep, m_tstrb, m_tlast, m_tuser, m_tid, m_tdest}, prev_snap);
        end
        if (m_tvalid && m_tready)
            q.push_back('{m_tdata, m_tlast, m_tuser, m_tid, src_tid, m_tdest, m_tkeep, cyc});
        prev_stall = m_tvalid && !m_tready;
        prev_snap  = {m_tdata, m_tkeep, m_tstrb, m_tlast, m_tuser, m_tid, m_tdest};
    end

    // Sink ready driver; when randomised, s0_tready must not react to it.
    always @(negedge aclk) begin
        rdy_before = s0_tready;
        m_tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        #1;
        if (rand_ready) check("s0_tready_indep", s0_tready, rdy_before);
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    task automatic wait_ready(input int port);
        int g = 0;
        while (!(port == 0 ? s0_tready : s1_tready)) begin
            @(negedge aclk);
            g++;
            if (g > 1000) begin
                $display("FAIL ready_timeout: port %0d never became ready", port);
                $fatal(1, "ready timeout");
            end
        end
    endtask

    task automatic send_pkt(input int port, input int len, input logic [DATAW-1:0] base,
                            input logic tidv, input logic dest);
        for (int i = 0; i < len; i++) begin
            logic [KW-1:0] k;
            k = (i == len - 1) ? 6'h07 : 6'h3F;
            if (port == 0) begin
                s0_tvalid = 1'b1; s0_tdata = base + DATAW'(i); s0_tlast = (i == len - 1);
                s0_tuser = i[0]; s0_tkeep = k; s0_tstrb = k; s0_tid = tidv; s0_tdest = dest;
            end else begin
                s1_tvalid = 1'b1; s1_tdata = base + DATAW'(i); s1_tlast = (i == len - 1);
                s1_tuser = i[0]; s1_tkeep = k; s1_tstrb = k; s1_tid = tidv; s1_tdest = dest;
            end
            wait_ready(port);
            @(negedge aclk);
        end
        if (port == 0) s0_tvalid = 1'b0;
        else           s1_tvalid = 1'b0;
    endtask

    task automatic do_reset();
        areset = 1'b1;
        repeat (2) @(negedge aclk);
        areset = 1'b0;
        q.delete();
    endtask

    initial begin
        int t0;
        int bad;
        rec_t r;

        // Reset state
        repeat (2) @(negedge aclk);
        check("rst_grant", grant, 2'b00);
        check("rst_tready", {s0_tready, s1_tready}, 2'b00);
        check("rst_m_tvalid", m_tvalid, 1'b0);
        check("rst_m_fields", {m_tdata, m_tkeep, m_tstrb, m_tlast, m_tuser, m_tid, m_tdest}, 64'd0);
        check("rst_counters", {pkt_cnt0, pkt_cnt1}, 32'd0);
        areset = 1'b0;
        @(negedge aclk);

        // Single source, 4-beat packet 1..4
        t0 = cyc;
        send_pkt(0, 4, 48'd1, 1'b1, 1'b1);
        repeat (4) @(negedge aclk);
        check("single_count", q.size(), 4);
        for (int k = 0; k < 4; k++) begin
            r = at(k);
            check("single_data", r.d, 48'(k + 1));
            check("single_cycle", r.cyc, t0 + 2 + k);
            check("single_side", {r.last, r.user, r.tid, r.dest}, {(k == 3), 1'(k % 2), 1'b0, 1'b1});
        end
        check("single_keep_last", at(3).keep, 6'h07);
        check("single_tid_src", at(0).tid_src, 1'b1);
        check("single_cnt0", pkt_cnt0, 16'd1);

        // Tie after reset: s0 first, no interleave
        do_reset();
        fork
            send_pkt(0, 2, 48'hA0, 1'b0, 1'b0);
            send_pkt(1, 2, 48'hB0, 1'b1, 1'b1);
        join
        repeat (4) @(negedge aclk);
        check("tie_count", q.size(), 4);
        check("tie_order", {at(0).d[7:0], at(1).d[7:0], at(2).d[7:0], at(3).d[7:0]}, 32'hA0A1B0B1);
        check("tie_tid", {at(0).tid, at(1).tid, at(2).tid, at(3).tid}, 4'b0011);
        q.delete();
        fork
            send_pkt(0, 2, 48'hC0, 1'b0, 1'b0);
            send_pkt(1, 2, 48'hD0, 1'b1, 1'b1);
        join
        repeat (4) @(negedge aclk);
        check("tie2_order", {at(0).d[7:0], at(1).d[7:0], at(2).d[7:0], at(3).d[7:0]}, 32'hC0C1D0D1);
        check("tie2_counters", {pkt_cnt0, pkt_cnt1}, {16'd2, 16'd2});

        // Fairness: both ports continuously requesting
        q.delete();
        fork
            for (int j = 0; j < 10; j++) send_pkt(0, 2, 48'h1000 + 48'(j * 16), 1'b0, 1'b0);
            for (int j = 0; j < 10; j++) send_pkt(1, 2, 48'h2000 + 48'(j * 16), 1'b1, 1'b1);
        join
        repeat (4) @(negedge aclk);
        check("fair_count", q.size(), 40);
        bad = 0;
        for (int p = 0; p < 20; p++) begin
            r = at(2 * p);
            if (r.tid !== 1'(p % 2)) bad++;
            if (r.d !== ((p % 2 == 0) ? 48'h1000 : 48'h2000) + 48'((p / 2) * 16)) bad++;
        end
        check("fair_alternate", bad, 0);
        check("fair_counters", {pkt_cnt0, pkt_cnt1}, {16'd12, 16'd12});

        // Backpressure: random sink ready on a 16-beat packet
        q.delete();
        rand_ready = 1'b1;
        send_pkt(0, 16, 48'h300, 1'b0, 1'b0);
        for (int g = 0; g < 1000 && q.size() < 16; g++) @(negedge aclk);
        rand_ready = 1'b0;
        repeat (3) @(negedge aclk);
        check("bp_count", q.size(), 16);
        bad = 0;
        for (int k = 0; k < 16; k++) if (at(k).d !== 48'h300 + 48'(k)) bad++;
        check("bp_order", bad, 0);
        check("bp_last", at(15).last, 1'b1);

        // Reset on beat 3 of an 8-beat packet
        s0_tvalid = 1'b1;
        s0_tlast  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            s0_tdata = 48'h400 + 48'(i);
            wait_ready(0);
            if (i == 2) areset = 1'b1;
            @(negedge aclk);
        end
        s0_tvalid = 1'b0;
        check("mid_rst_tvalid", m_tvalid, 1'b0);
        check("mid_rst_grant", grant, 2'b00);
        check("mid_rst_counters", {pkt_cnt0, pkt_cnt1}, 32'd0);
        areset = 1'b0;
        q.delete();
        send_pkt(1, 2, 48'h500, 1'b1, 1'b0);
        repeat (4) @(negedge aclk);
        check("post_rst_count", q.size(), 2);
        check("post_rst_data", {at(0).d[15:0], at(1).d[15:0], at(1).last}, {16'h500, 16'h501, 1'b1});
        check("post_rst_cnt1", pkt_cnt1, 16'd1);

        // Saturation: preload the counter close to the limit
        do_reset();
        force dut.cnt1 = 16'hFFFD;
        @(negedge aclk);
        release dut.cnt1;
        @(negedge aclk);
        check("sat_preload", pkt_cnt1, 16'hFFFD);
        send_pkt(1, 1, 48'h600, 1'b0, 1'b1);
        check("sat_fffe", pkt_cnt1, 16'hFFFE);
        send_pkt(1, 1, 48'h601, 1'b0, 1'b1);
        send_pkt(1, 1, 48'h602, 1'b0, 1'b1);
        check("sat_hold", pkt_cnt1, 16'hFFFF);
        send_pkt(0, 1, 48'h700, 1'b1, 1'b0);
        repeat (3) @(negedge aclk);
        check("sat_count", q.size(), 4);
        check("tid_port_s1", {at(0).tid, at(0).tid_src}, 2'b10);
        check("tid_port_s0", {at(3).tid, at(3).tid_src, at(3).d[11:0]}, {2'b01, 12'h700});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
